// File: rtl/payload_sum_tx.sv
// Packet pass-through with an appended checksum trailer: every payload word is
// forwarded unchanged, then a trailer carrying the 32-bit lane sum and word count.
module payload_sum_tx #(
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] s_payload,
  input  logic         s_valid,
  input  logic         s_last,
  output logic         s_ready,
  output logic [255:0] m_data,
  output logic         m_valid,
  output logic         m_last,
  input  logic         m_ready,
  output logic         m_is_sum,
  output logic [15:0]  pkt_count,
  output logic         err_overlength
);

  typedef enum logic [1:0] {IDLE, DATA, TRAILER} state_t;

  localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);

  state_t      state, state_next;
  logic [31:0] acc;
  logic [15:0] word_cnt;
  logic [31:0] lane_sum;
  logic        out_free;
  logic        accept;
  logic        load_trailer;
  logic        hit_max;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no latch is inferred; clocked blocks use '<=' only.
  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < 8; k++) begin
      lane_sum = lane_sum + s_payload[32*k +: 32];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DATA: begin
        if (accept) state_next = (s_last || hit_max) ? TRAILER : DATA;
      end
      TRAILER: begin
        if (out_free) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output / handshake logic
  always_comb begin
    out_free     = !m_valid || m_ready;
    s_ready      = !rst && (state != TRAILER) && out_free;
    accept       = s_valid && s_ready;
    load_trailer = (state == TRAILER) && out_free;
    hit_max      = (word_cnt + 16'd1) == MAX_CNT;
  end

  // Accumulator and word counter; the trailer load restarts them for the next packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc            <= '0;
      word_cnt       <= '0;
      err_overlength <= 1'b0;
    end else if (load_trailer) begin
      acc      <= '0;
      word_cnt <= '0;
    end else if (accept) begin
      acc      <= acc + lane_sum;
      word_cnt <= word_cnt + 16'd1;
      if (hit_max && !s_last) err_overlength <= 1'b1;
    end
  end

  // Single output register; contents only change when empty or being taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_data   <= '0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      m_is_sum <= 1'b0;
    end else if (accept) begin
      m_data   <= s_payload;
      m_valid  <= 1'b1;
      m_last   <= 1'b0;
      m_is_sum <= 1'b0;
    end else if (load_trailer) begin
      m_data   <= {208'd0, word_cnt, acc};
      m_valid  <= 1'b1;
      m_last   <= 1'b1;
      m_is_sum <= 1'b1;
    end else if (m_ready) begin
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      m_is_sum <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                               pkt_count <= '0;
    else if (m_valid && m_ready && m_last) pkt_count <= pkt_count + 16'd1;
  end

endmodule

// File: tb/tb_payload_sum_tx.sv
// Directed bench for payload_sum_tx (MAX_WORDS=4): latency, wrap, stall,
// overlength, mid-packet reset and back-to-back packets.
module tb_payload_sum_tx;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] s_payload;
  logic         s_valid;
  logic         s_last;
  logic         s_ready;
  logic [255:0] m_data;
  logic         m_valid;
  logic         m_last;
  logic         m_ready;
  logic         m_is_sum;
  logic [15:0]  pkt_count;
  logic         err_overlength;

  int n_checks = 0;
  int n_pass   = 0;

  logic [255:0] q_data[$];
  logic         q_last[$];
  logic         q_sum[$];
  int           low_total = 0;

  payload_sum_tx #(.MAX_WORDS(4)) dut (
    .clk(clk), .rst(rst),
    .s_payload(s_payload), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .m_is_sum(m_is_sum), .pkt_count(pkt_count), .err_overlength(err_overlength)
  );

  always #5 clk = ~clk;

  // Inputs change at posedge+1, so the falling edge sees a settled handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && m_ready) begin
        q_data.push_back(m_data);
        q_last.push_back(m_last);
        q_sum.push_back(m_is_sum);
      end
      if (!s_ready) low_total++;
    end
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [255:0] mk_word(input logic [31:0] l0, input logic [31:0] step);
    logic [255:0] w;
    for (int k = 0; k < 8; k++) w[32*k +: 32] = l0 + step * 32'(k);
    return w;
  endfunction

  function automatic logic [255:0] trl(input logic [31:0] sum, input logic [15:0] cnt);
    return {208'd0, cnt, sum};
  endfunction

  task automatic send_word(input logic [255:0] w, input logic last);
    bit done;
    done = 1'b0;
    s_payload = w;
    s_last    = last;
    s_valid   = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = s_ready;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (!done) check("send_timeout", 256'(0), 256'(1));
  endtask

  task automatic drain();
    m_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input int idx, input logic [255:0] data, input logic last);
    if (idx < q_data.size()) begin
      check({tag, "_data"}, q_data[idx], data);
      check({tag, "_last"}, 256'(q_last[idx]), 256'(last));
      check({tag, "_sum"},  256'(q_sum[idx]),  256'(last));
    end else begin
      check({tag, "_missing"}, 256'(0), 256'(1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] w1, wa, wb, wff;
    int base, low0;
    w1  = mk_word(32'd1, 32'd1);          // lanes 1..8, sum 0x24
    wa  = w1;
    wb  = mk_word(32'h10, 32'd1);         // sum 0x9C
    wff = mk_word(32'hFFFF_FFFF, 32'd0);  // sum 0xFFFFFFF8

    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_payload = '0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_m_valid",  256'(m_valid),        256'(0));
    check("rst_m_last",   256'(m_last),         256'(0));
    check("rst_m_is_sum", 256'(m_is_sum),       256'(0));
    check("rst_m_data",   m_data,               256'(0));
    check("rst_pkt",      256'(pkt_count),      256'(0));
    check("rst_err",      256'(err_overlength), 256'(0));
    check("rst_s_ready",  256'(s_ready),        256'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_s_ready", 256'(s_ready), 256'(1));
    @(posedge clk); #1;

    // Single word: payload at +1, trailer at +2.
    s_payload = w1; s_valid = 1'b1; s_last = 1'b1;
    @(negedge clk);
    check("single_s_ready", 256'(s_ready), 256'(1));
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    check("single_p_valid", 256'(m_valid), 256'(1));
    check("single_p_last",  256'(m_last),  256'(0));
    check("single_p_data",  m_data,        w1);
    check("single_bubble",  256'(s_ready), 256'(0));
    @(negedge clk);
    check("single_t_last",  256'(m_last),   256'(1));
    check("single_t_sum",   256'(m_is_sum), 256'(1));
    check("single_t_data",  m_data,         trl(32'h24, 16'd1));
    check("single_t_ready", 256'(s_ready),  256'(1));
    @(negedge clk);
    check("single_idle",    256'(m_valid),   256'(0));
    check("single_pkt",     256'(pkt_count), 256'(1));
    @(posedge clk); #1;

    // Lane-sum wrap.
    base = q_data.size();
    send_word(wff, 1'b0);
    send_word(wff, 1'b1);
    drain();
    check("wrap_beats", 256'(q_data.size() - base), 256'(3));
    beat("wrap_w0", base, wff, 1'b0);
    beat("wrap_trl", base + 2, trl(32'hFFFF_FFF0, 16'd2), 1'b1);
    check("wrap_pkt", 256'(pkt_count), 256'(2));

    // Backpressure mid-packet: 0x24 + 0x9C + 0x9C0 = 0xA80.
    base = q_data.size();
    send_word(w1, 1'b0);
    m_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_hold_data",  m_data,         w1);
      check("bp_hold_valid", 256'(m_valid),  256'(1));
      check("bp_s_ready",    256'(s_ready),  256'(0));
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    send_word(wb, 1'b0);
    send_word(mk_word(32'h100, 32'h10), 1'b1);
    drain();
    check("bp_beats", 256'(q_data.size() - base), 256'(4));
    beat("bp_w0", base, w1, 1'b0);
    beat("bp_w1", base + 1, wb, 1'b0);
    beat("bp_trl", base + 3, trl(32'hA80, 16'd3), 1'b1);
    check("bp_pkt", 256'(pkt_count), 256'(3));

    // Overlength: 6 words with MAX_WORDS=4 -> trailers of 4 and 2 words.
    check("ovl_err_before", 256'(err_overlength), 256'(0));
    base = q_data.size();
    for (int i = 0; i < 6; i++) send_word(w1, i == 5);
    drain();
    check("ovl_beats", 256'(q_data.size() - base), 256'(8));
    beat("ovl_trl1", base + 4, trl(32'h90, 16'd4), 1'b1);
    beat("ovl_new_w", base + 5, w1, 1'b0);
    beat("ovl_trl2", base + 7, trl(32'h48, 16'd2), 1'b1);
    check("ovl_err_after", 256'(err_overlength), 256'(1));
    check("ovl_pkt", 256'(pkt_count), 256'(5));

    // Reset after 3 words of a packet: no trailer for the aborted packet.
    for (int i = 0; i < 3; i++) send_word(wb, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst2_m_valid", 256'(m_valid),        256'(0));
    check("rst2_err",     256'(err_overlength), 256'(0));
    check("rst2_pkt",     256'(pkt_count),      256'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    base = q_data.size();
    send_word(w1, 1'b1);
    drain();
    check("rst2_beats", 256'(q_data.size() - base), 256'(2));
    beat("rst2_trl", base + 1, trl(32'h24, 16'd1), 1'b1);
    check("rst2_pkt_after", 256'(pkt_count), 256'(1));

    // Back-to-back 2-word packets: one s_ready bubble each.
    base = q_data.size();
    low0 = low_total;
    for (int p = 0; p < 3; p++) begin
      send_word(wa, 1'b0);
      send_word(wb, 1'b1);
    end
    drain();
    check("b2b_beats", 256'(q_data.size() - base), 256'(9));
    beat("b2b_trl0", base + 2, trl(32'hC0, 16'd2), 1'b1);
    beat("b2b_trl1", base + 5, trl(32'hC0, 16'd2), 1'b1);
    beat("b2b_trl2", base + 8, trl(32'hC0, 16'd2), 1'b1);
    beat("b2b_w3", base + 3, wa, 1'b0);
    check("b2b_bubbles", 256'(low_total - low0), 256'(3));
    check("b2b_pkt", 256'(pkt_count), 256'(4));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/payload_sum_tx.md
PAYLOAD_SUM_TX -- requirements
Module: payload_sum_tx

Interface
REQ-001 Parameter MAX_WORDS, default 64, SHALL set the maximum number of payload words per packet (range 1..65535).
REQ-002 The block SHALL use one clock and a synchronous, active-high reset. The ports are clk and rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 s_payload  input  256  payload word; lane k = s_payload[32k+31:32k], k=0..7.
REQ-006 s_valid  input  1  s_payload valid.
REQ-007 s_last  input  1  marks the last payload word of a packet.
REQ-008 s_ready  output  1  block accepts s_payload this cycle.
REQ-009 m_data  output  256  output word (payload or trailer).
REQ-010 m_valid  output  1  m_data valid.
REQ-011 m_last  output  1  marks the trailer beat (last beat of packet).
REQ-012 m_ready  input  1  downstream accepts m_data.
REQ-013 m_is_sum  output  1  high together with m_last on the trailer beat.
REQ-014 pkt_count  output  16  count of trailers accepted downstream, wraps at 2^16.
REQ-015 err_overlength  output  1  sticky overlength flag.

Function
REQ-016 Input handshake: a word is accepted when s_valid && s_ready. Output handshake: a word is taken when m_valid && m_ready.
REQ-017 Output stage SHALL be a single register.
- s_ready = !rst && state!=TRAILER && (!m_valid || m_ready).
REQ-018 An accepted word SHALL appear on m_data the next cycle with m_last=0 and m_is_sum=0.
REQ-019 While m_valid && !m_ready, m_data, m_last and m_is_sum SHALL be held stable.
REQ-020 FSM states SHALL be IDLE, DATA and TRAILER.
- IDLE: accept with s_last -> TRAILER; accept without s_last -> DATA.
- DATA: accept with s_last, or with word count reaching MAX_WORDS -> TRAILER.
- TRAILER: loads the trailer in the first cycle where !m_valid || m_ready, then -> IDLE.
REQ-021 Accumulator: on every accepted word, acc SHALL become (acc + lane0 + ... + lane7) mod 2^32.
REQ-022 Word counter (16-bit) SHALL increment on every accepted word.
REQ-023 Trailer format SHALL be:
- m_data[31:0] = final acc, including the last word;
- m_data[47:32] = word count;
- m_data[255:48] = 0;
- m_last = 1, m_is_sum = 1.
REQ-024 Loading the trailer SHALL clear acc and the word counter to 0.
REQ-025 With m_ready held at 1, latency SHALL be:
- last payload word accepted at cycle N is output at N+1;
- trailer is output at N+2;
- next input is accepted no earlier than N+2, giving exactly one input bubble per packet.
REQ-026 Overlength: when the MAX_WORDS-th word is accepted without s_last, the block SHALL treat it as last and emit the trailer.
- err_overlength SHALL be set and held until rst.
- Subsequent words SHALL form a new packet.
REQ-027 pkt_count SHALL increment on each taken trailer beat (m_valid && m_ready && m_last).
REQ-028 A payload beat and the trailer SHALL never be output in the same cycle. A word SHALL never be dropped or duplicated.

Reset
REQ-029 While rst=1 the block SHALL drive:
- state=IDLE, acc=0, word count=0;
- m_valid=0, m_last=0, m_is_sum=0, m_data=0;
- pkt_count=0, err_overlength=0, s_ready=0.
REQ-030 Reset during DATA or TRAILER SHALL discard the partial packet; no trailer is emitted for it.
REQ-031 s_ready SHALL be 1 in the first cycle after rst deasserts, provided m_valid=0.

Verification
REQ-032 Single word: lanes 1..8, s_last=1, m_ready=1 -> payload word at +1; trailer at +2 with [31:0]=0x24, [47:32]=1; pkt_count=1.
REQ-033 Wrap: two words with all lanes 0xFFFFFFFF, last on word 2 -> trailer sum=0xFFFFFFF0, count=2.
REQ-034 Backpressure: m_ready=0 for 3 cycles mid-packet -> m_data held, s_ready=0, final sum and count unchanged versus the no-stall run.
REQ-035 Overlength with MAX_WORDS=4: 6 words, s_last on word 6 ->
- trailer after word 4 with count=4 and err_overlength=1;
- then a second trailer with count=2;
- pkt_count=2.
REQ-036 Reset mid-packet after 3 words, then a 1-word packet of lanes 1..8 -> no trailer for the aborted packet; new trailer sum=0x24, count=1, pkt_count=1.
REQ-037 Back-to-back: s_valid held high, three 2-word packets, m_ready=1 -> three trailers, exactly one s_ready-low cycle per packet.
